sdft_sequencer: RTL
===================

Name: sdft_sequencer

Overview:
Front-end controller that feeds a streaming sample source into the sliding DFT core. It buffers incoming signed samples in a small FIFO and issues each one to the core with the core's start/ready handshake, one at a time. It tracks how many samples the core has absorbed and flags when the DFT window is primed and when each full frame of freq_bins samples completes. It sits between the ADC/sample interface and the sdft instance.

Parameters:
data_width, 8, sample width in bits (signed two's complement); must match the core.
freq_bins, 128, core window length; power of two, >=2.
fifo_depth, 4, sample FIFO entries; power of two, >=2.
decim, 4, decimation ratio, used only when SEQ_DECIMATE_EN is defined; >=1.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
in_sample  in  data_width  signed input sample.
in_valid  in  1  in_sample valid.
in_ready  out  1  FIFO can accept; equals !full (combinational from registered count).
sdft_sample  out  data_width  sample presented to the core; registered.
sdft_start  out  1  start request to the core; registered.
sdft_ready  in  1  core ready; low while the core is processing.
spectrum_valid  out  1  sticky; high once freq_bins samples have been completed by the core.
frame_tick  out  1  one-cycle pulse per freq_bins completed samples.
overrun  out  1  sticky; in_valid seen while FIFO full.
busy  out  1  high when the FSM is not IDLE or the FIFO is non-empty.

Behaviour:
- Reset (asynchronous): FSM=IDLE, FIFO empty, sample counter=0. Outputs: sdft_start=0, sdft_sample=0, spectrum_valid=0, frame_tick=0, overrun=0. in_ready=1 and busy=0 follow from empty/IDLE.
- FIFO push occurs on in_valid&&in_ready. Pop occurs in IDLE only. Push and pop in the same cycle leave the count unchanged. Pointers wrap modulo fifo_depth. There is no push when full and no pop when empty.
- in_valid while full: sample dropped; overrun set (cleared only by reset).
- FSM states:
  - IDLE: if FIFO non-empty and sdft_ready=1, pop the head into sdft_sample, set sdft_start=1, go to LAUNCH. Otherwise hold.
  - LAUNCH: hold sdft_start=1 and sdft_sample stable until sdft_ready=0 is sampled. On that edge, clear sdft_start and go to RUN.
  - RUN: wait for sdft_ready=1. On that edge, increment the sample counter and go to IDLE.
- Counter: width log2(freq_bins); wraps from freq_bins-1 to 0. On the wrap, frame_tick=1 for exactly one cycle and spectrum_valid is set.
- Latency: when the FIFO is empty and the core is idle, a sample pushed at edge k gives sdft_start=1 after edge k+1. The next IDLE pop can occur at the edge after RUN completes, so there is 1 idle cycle between consecutive core operations.
- sdft_sample changes only on a pop. It holds its value through LAUNCH and RUN.
- Reset mid-operation: everything returns to its reset state immediately, and an in-flight core operation is not tracked. After reset, the FSM waits in IDLE for sdft_ready=1 before the next launch.
- If sdft_ready is already 0 while in IDLE, no launch occurs.

Optional Feature:
SEQ_DECIMATE_EN
- Defined: a counter of 0..decim-1 advances on each accepted input (in_valid&&in_ready). Only the sample arriving when the counter is 0 is written to the FIFO; the rest are accepted and discarded. The counter resets to 0. in_ready and overrun behave as above.
- Not defined: every accepted sample is written, and the decim parameter is ignored.

Test Plan:
- Single sample: push 8'sd100 with the core model idle. Expect sdft_start=1 at edge k+1 and sdft_sample=100. sdft_start falls on the edge after the model drops sdft_ready. Counter=1 after the model raises sdft_ready.
- Square wave, 64x -100 then 64x +100, repeated twice with freq_bins=128. Expect frame_tick pulses exactly after the 128th and 256th completions. spectrum_valid rises with the first pulse and stays high. Samples reach the core in order.
- FIFO full: hold the model's sdft_ready=0 and push 5 samples with fifo_depth=4. Expect in_ready=0 after the 4th push, the 5th sample dropped and overrun=1. Release the model: exactly 4 samples are issued, in order.
- Simultaneous push/pop: with the FIFO at 2 entries, push while IDLE pops. Expect the count to stay at 2 and no sample lost.
- Reset in RUN: assert reset mid-operation. Expect sdft_start=0, FIFO empty, counter=0, spectrum_valid=0 and overrun=0 at once. Normal operation resumes after reset is released.
- SEQ_DECIMATE_EN with decim=4: push samples 1..8. Expect only samples 1 and 5 to be issued to the core.

Source files
------------

// File: rtl/sdft_sequencer.sv
// Sample FIFO and start/ready launcher in front of the sliding DFT core; tracks window priming and frame completion.
// Optional build macro SEQ_DECIMATE_EN: keep only every decim-th accepted input sample.
module sdft_sequencer #(
    parameter int data_width = 8,
    parameter int freq_bins  = 128,
    parameter int fifo_depth = 4,
    parameter int decim      = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic signed [data_width-1:0] in_sample,
    input  logic                         in_valid,
    output logic                         in_ready,
    output logic signed [data_width-1:0] sdft_sample,
    output logic                         sdft_start,
    input  logic                         sdft_ready,
    output logic                         spectrum_valid,
    output logic                         frame_tick,
    output logic                         overrun,
    output logic                         busy
);
    localparam int CW = $clog2(freq_bins);
    localparam int PW = $clog2(fifo_depth);
    localparam int NW = PW + 1;

    typedef enum logic [1:0] {IDLE, LAUNCH, RUN} state_t;

    state_t                       state_q, state_d;
    logic [PW-1:0]                wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]                rd_ptr_q, rd_ptr_d;
    logic [NW-1:0]                count_q, count_d;
    logic [CW-1:0]                cnt_q, cnt_d;
    logic signed [data_width-1:0] sample_q, sample_d;
    logic                         start_q, start_d;
    logic                         sv_q, sv_d;
    logic                         tick_q, tick_d;
    logic                         ovr_q, ovr_d;
    logic signed [data_width-1:0] mem_q [fifo_depth];

    logic full, empty, accept, wr_en, pop;

    assign full   = (count_q == NW'(fifo_depth));
    assign empty  = (count_q == '0);
    assign accept = in_valid && !full;
    // Launch only when the core is idle; a core that is already busy blocks the pop.
    assign pop    = (state_q == IDLE) && !empty && sdft_ready;

`ifdef SEQ_DECIMATE_EN
    localparam int DW = (decim > 1) ? $clog2(decim) : 1;
    logic [DW-1:0] dec_q, dec_d;

    always_comb begin
        dec_d = dec_q;
        if (accept) begin
            dec_d = (dec_q == DW'(decim - 1)) ? '0 : dec_q + 1'b1;
        end
    end

    assign wr_en = accept && (dec_q == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) dec_q <= '0;
        else       dec_q <= dec_d;
    end
`else
    // decim is irrelevant here; only its legality is folded in.
    assign wr_en = accept && (decim >= 1);
`endif

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        cnt_d    = cnt_q;
        sample_d = sample_q;
        start_d  = start_q;
        sv_d     = sv_q;
        tick_d   = 1'b0;
        ovr_d    = ovr_q;

        if (wr_en) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop)   rd_ptr_d = rd_ptr_q + 1'b1;
        case ({wr_en, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (in_valid && full) ovr_d = 1'b1;

        unique case (state_q)
            IDLE: begin
                if (pop) begin
                    sample_d = mem_q[rd_ptr_q];
                    start_d  = 1'b1;
                    state_d  = LAUNCH;
                end
            end
            LAUNCH: begin
                if (!sdft_ready) begin
                    start_d = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (sdft_ready) begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = IDLE;
                    if (cnt_q == CW'(freq_bins - 1)) begin
                        tick_d = 1'b1;
                        sv_d   = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            cnt_q    <= '0;
            sample_q <= '0;
            start_q  <= 1'b0;
            sv_q     <= 1'b0;
            tick_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            cnt_q    <= cnt_d;
            sample_q <= sample_d;
            start_q  <= start_d;
            sv_q     <= sv_d;
            tick_q   <= tick_d;
            ovr_q    <= ovr_d;
        end
    end

    // Storage needs no reset: entries are only read after being written.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= in_sample;
    end

    assign in_ready       = !full;
    assign sdft_sample    = sample_q;
    assign sdft_start     = start_q;
    assign spectrum_valid = sv_q;
    assign frame_tick     = tick_q;
    assign overrun        = ovr_q;
    assign busy           = (state_q != IDLE) || !empty;
endmodule
